// File: rtl/calc_cmd_seq.sv
// calc_cmd_seq
//   Command sequencer for the UART calculator. Collects operand, operand and
//   operator bytes from the UART receiver and echoes each accepted byte. It
//   drives the 4-bit add/sub ALU, then returns the result as one ASCII byte.
//   A CR/LF can optionally follow the result byte. The last result is shown
//   on the LEDs.
//
// Ports
//   clk12m       in   system clock
//   rst_n        in   asynchronous active-low reset
//   rx_data      in   [7:0] received byte, valid with rx_data_rdy
//   rx_data_rdy  in   one-cycle receive strobe
//   tx_busy      in   transmitter cannot take a byte this cycle
//   tx_data      out  [7:0] byte to transmit (held until the next send)
//   tx_data_rdy  out  one-cycle send strobe
//   alu_a        out  [3:0] operand 1
//   alu_b        out  [3:0] operand 2
//   alu_sub      out  1 = a-b, 0 = a+b
//   alu_go       out  one-cycle ALU start strobe
//   alu_res      in   [4:0] {carry/borrow, sum}, valid with alu_done
//   alu_done     in   one-cycle ALU completion strobe
//   leds         out  [4:0] last ALU result
//   busy         out  sequencer is not idle in WAIT_OP1
//   err_ovr      out  sticky: a received byte was dropped
//   err_tmo      out  sticky: the ALU did not answer in time
module calc_cmd_seq #(
    parameter int ECHO_EN     = 1,
    parameter int SEND_CRLF   = 0,
    parameter int ALU_TIMEOUT = 16
) (
    input  logic       clk12m,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_data_rdy,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_data_rdy,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_sub,
    output logic       alu_go,
    input  logic [4:0] alu_res,
    input  logic       alu_done,
    output logic [4:0] leds,
    output logic       busy,
    output logic       err_ovr,
    output logic       err_tmo
);

    localparam int             CW       = $clog2(ALU_TIMEOUT + 1);
    localparam logic [CW-1:0]  TMO_LAST = CW'(ALU_TIMEOUT - 1);
    // index of the last byte of the result sequence (result, or result/CR/LF)
    localparam logic [1:0]     RES_LAST = (SEND_CRLF != 0) ? 2'd2 : 2'd0;

    typedef enum logic [2:0] {
        WAIT_OP1,
        WAIT_OP2,
        WAIT_OPR,
        EXEC,
        RESULT
    } state_t;

    state_t        state, state_nxt;

    logic          pend_vld;
    logic [CW-1:0] tmo_cnt;
    logic [7:0]    res_char;
    logic [1:0]    res_cnt;

    logic is_operand, is_operator, is_esc, in_wait;
    logic rx_ovr, rx_ok, esc_hit;
    logic acc_op1, acc_op2, acc_opr;
    logic echo_load, res_load, res_fin;
    logic tx_send, alu_take, alu_tmo;
    logic [7:0] res_byte, load_byte;

    // Byte classification and event decode
    always_comb begin
        is_operand  = (rx_data[7:4] == 4'h3);
        is_operator = (rx_data == 8'h2B) || (rx_data == 8'h2D);
        is_esc      = (rx_data == 8'h1B);
        in_wait     = (state == WAIT_OP1) || (state == WAIT_OP2) || (state == WAIT_OPR);

        // Any strobe is dropped while the previous echo is still queued or
        // while a command is in flight.
        rx_ovr  = rx_data_rdy && (pend_vld || !in_wait);
        rx_ok   = rx_data_rdy && !rx_ovr;
        esc_hit = rx_ok && is_esc;
        acc_op1 = rx_ok && (state == WAIT_OP1) && is_operand;
        acc_op2 = rx_ok && (state == WAIT_OP2) && is_operand;
        acc_opr = rx_ok && (state == WAIT_OPR) && is_operator;

        tx_send  = pend_vld && !tx_busy;
        alu_take = (state == EXEC) && alu_done;
        // counter only runs after the go pulse, so it reaches TMO_LAST in
        // the ALU_TIMEOUT-th cycle after alu_go
        alu_tmo  = (state == EXEC) && !alu_done && !alu_go && (tmo_cnt == TMO_LAST);

        echo_load = (ECHO_EN != 0) && (acc_op1 || acc_op2 || acc_opr);
        res_load  = (state == RESULT) && !pend_vld && (res_cnt <= RES_LAST);
        res_fin   = (state == RESULT) && tx_send && (res_cnt == RES_LAST + 2'd1);

        case (res_cnt)
            2'd0:    res_byte = res_char;
            2'd1:    res_byte = 8'h0D;
            default: res_byte = 8'h0A;
        endcase
        load_byte = echo_load ? rx_data : res_byte;
    end

    // FSM: state register
    always_ff @(posedge clk12m or negedge rst_n) begin
        if (!rst_n) state <= WAIT_OP1;
        else        state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_OP1: if (esc_hit) state_nxt = WAIT_OP1;
                      else if (acc_op1) state_nxt = WAIT_OP2;
            WAIT_OP2: if (esc_hit) state_nxt = WAIT_OP1;
                      else if (acc_op2) state_nxt = WAIT_OPR;
            WAIT_OPR: if (esc_hit) state_nxt = WAIT_OP1;
                      else if (acc_opr) state_nxt = EXEC;
            EXEC:     if (alu_take || alu_tmo) state_nxt = RESULT;
            RESULT:   if (res_fin) state_nxt = WAIT_OP1;
            default:  state_nxt = WAIT_OP1;
        endcase
    end

    // FSM: combinational outputs
    always_comb begin
        tx_data_rdy = tx_send;
        busy        = (state != WAIT_OP1);
    end

    // Datapath, tx pending register and flags
    always_ff @(posedge clk12m or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld <= 1'b0;
            tx_data  <= 8'h00;
            alu_a    <= 4'h0;
            alu_b    <= 4'h0;
            alu_sub  <= 1'b0;
            alu_go   <= 1'b0;
            tmo_cnt  <= '0;
            res_char <= 8'h00;
            res_cnt  <= 2'd0;
            leds     <= 5'h00;
            err_ovr  <= 1'b0;
            err_tmo  <= 1'b0;
        end else begin
            // echo and result loads only happen with the register empty,
            // so a load never collides with a send
            if (echo_load || res_load) begin
                pend_vld <= 1'b1;
                tx_data  <= load_byte;
            end else if (tx_send) begin
                pend_vld <= 1'b0;
            end

            if (acc_op1) alu_a <= rx_data[3:0];
            if (acc_op2) alu_b <= rx_data[3:0];
            if (acc_opr) alu_sub <= (rx_data == 8'h2D);
            alu_go <= acc_opr;

            if (acc_opr)
                tmo_cnt <= '0;
            else if ((state == EXEC) && !alu_go)
                tmo_cnt <= tmo_cnt + 1'b1;

            if (alu_take) begin
                leds     <= alu_res;
                res_char <= {(alu_res[4] ? 4'h5 : 4'h3), alu_res[3:0]};
            end else if (alu_tmo) begin
                res_char <= 8'h21;
            end

            if (acc_opr)       res_cnt <= 2'd0;
            else if (res_load) res_cnt <= res_cnt + 2'd1;

            if (esc_hit)     err_ovr <= 1'b0;
            else if (rx_ovr) err_ovr <= 1'b1;

            if (esc_hit)      err_tmo <= 1'b0;
            else if (alu_tmo) err_tmo <= 1'b1;
        end
    end

endmodule
